// File: rtl/hazard_stall_unit.sv
// ID-stage stall controller: load-use and MDU-busy stalls plus a flush bubble; outputs are combinational (0 cycles).
// MDU occupancy is tracked by a down-counter. Define HAZARD_STATS_EN to add the saturating StallCycles counter.
module hazard_stall_unit #(
    parameter int unsigned MDU_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       IdValid,
    input  logic [4:0] IfIdRegRs,
    input  logic [4:0] IfIdRegRt,
    input  logic       IfIdUsesRt,
    input  logic       IdIsMdu,
    input  logic       IdIsMfhilo,
    input  logic       IdExMemRead,
    input  logic [4:0] IdExRegRt,
    input  logic       ExFlush,
    output logic       PcWrite,
    output logic       IfIdWrite,
    output logic       IdExBubble,
    output logic       MduBusy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] StallCycles
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_t;

    localparam logic [3:0] LP_LAT = 4'(MDU_LATENCY);

    mdu_state_t r_state;
    mdu_state_t w_state_nxt;
    logic [3:0] r_mdu_cnt;
    logic [3:0] w_mdu_cnt_nxt;

    logic w_busy;
    logic w_load_use;
    logic w_mdu_haz;
    logic w_flush;
    logic w_stall;
    logic w_issue;

    // Every hazard term is gated by rst_n so outputs sit at their idle values during reset.
    assign w_busy     = (r_mdu_cnt != 4'd0);
    assign w_load_use = rst_n & IdValid & IdExMemRead & (IdExRegRt != 5'd0) &
                        ((IdExRegRt == IfIdRegRs) | (IfIdUsesRt & (IdExRegRt == IfIdRegRt)));
    assign w_mdu_haz  = rst_n & IdValid & w_busy & (IdIsMdu | IdIsMfhilo);
    assign w_flush    = rst_n & ExFlush;
    assign w_stall    = (w_load_use | w_mdu_haz) & ~w_flush;
    assign w_issue    = rst_n & IdValid & IdIsMdu & ~w_stall & ~w_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mdu_cnt <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_mdu_cnt <= w_mdu_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mdu_cnt_nxt = r_mdu_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_mdu_cnt_nxt = LP_LAT;
                    w_state_nxt   = S_BUSY;
                end
            end
            S_BUSY: begin
                w_mdu_cnt_nxt = r_mdu_cnt - 4'd1;
                if (r_mdu_cnt <= 4'd1) begin
                    w_mdu_cnt_nxt = 4'd0;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_mdu_cnt_nxt = 4'd0;
            end
        endcase
    end

    // A flush still bubbles ID/EX but lets fetch run so the squashed slot is refilled.
    always_comb begin
        PcWrite    = 1'b1;
        IfIdWrite  = 1'b1;
        IdExBubble = 1'b0;
        MduBusy    = w_busy;
        if (w_flush) begin
            IdExBubble = 1'b1;
        end else if (w_stall) begin
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            IdExBubble = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= 16'd0;
        end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign StallCycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: expected {PcWrite,IfIdWrite,IdExBubble,MduBusy} queued at drive time, popped at the falling edge.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       IdValid;
    logic [4:0] IfIdRegRs;
    logic [4:0] IfIdRegRt;
    logic       IfIdUsesRt;
    logic       IdIsMdu;
    logic       IdIsMfhilo;
    logic       IdExMemRead;
    logic [4:0] IdExRegRt;
    logic       ExFlush;
    logic       PcWrite;
    logic       IfIdWrite;
    logic       IdExBubble;
    logic       MduBusy;
`ifdef HAZARD_STATS_EN
    logic [15:0] StallCycles;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    hazard_stall_unit #(.MDU_LATENCY(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .IdValid    (IdValid),
        .IfIdRegRs  (IfIdRegRs),
        .IfIdRegRt  (IfIdRegRt),
        .IfIdUsesRt (IfIdUsesRt),
        .IdIsMdu    (IdIsMdu),
        .IdIsMfhilo (IdIsMfhilo),
        .IdExMemRead(IdExMemRead),
        .IdExRegRt  (IdExRegRt),
        .ExFlush    (ExFlush),
        .PcWrite    (PcWrite),
        .IfIdWrite  (IfIdWrite),
        .IdExBubble (IdExBubble),
        .MduBusy    (MduBusy)
`ifdef HAZARD_STATS_EN
        ,
        .StallCycles(StallCycles)
`endif
    );

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       mdu;
        logic       mfh;
        logic       memrd;
        logic [4:0] exrt;
        logic       flush;
        logic [3:0] exp;
    } stim_t;

    function automatic stim_t mk(input int v, input int rs, input int rt, input int u,
                                 input int m, input int f, input int mr, input int er,
                                 input int fl, input logic [3:0] e);
        stim_t s;
        s.valid = 1'(v);
        s.rs    = 5'(rs);
        s.rt    = 5'(rt);
        s.uses  = 1'(u);
        s.mdu   = 1'(m);
        s.mfh   = 1'(f);
        s.memrd = 1'(mr);
        s.exrt  = 5'(er);
        s.flush = 1'(fl);
        s.exp   = e;
        return s;
    endfunction

    function automatic logic [3:0] obs();
        return {PcWrite, IfIdWrite, IdExBubble, MduBusy};
    endfunction

    // Drives one cycle of inputs and records what the outputs must be.
    task automatic drive(input stim_t s);
        IdValid     = s.valid;
        IfIdRegRs   = s.rs;
        IfIdRegRt   = s.rt;
        IfIdUsesRt  = s.uses;
        IdIsMdu     = s.mdu;
        IdIsMfhilo  = s.mfh;
        IdExMemRead = s.memrd;
        IdExRegRt   = s.exrt;
        ExFlush     = s.flush;
        exp_q.push_back(s.exp);
    endtask

    task automatic test_reset();
        stim_t s[$];
        logic [3:0] e;
        rst_n = 1'b0;
        s.push_back(mk(1, 5, 0, 0, 0, 0, 1, 5, 0, 4'b1100));
        s.push_back(mk(1, 5, 0, 0, 0, 0, 1, 5, 1, 4'b1100));
        s.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1100));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1100));
        foreach (s[i]) begin
            @(posedge clk); #1; drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL reset[%0d]: got %b expected %b", i, obs(), e); end
        end
        rst_n = 1'b1;
        @(posedge clk); #1; drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100));
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL reset_release: got %b expected %b", obs(), e); end
    endtask

    task automatic test_load_use_rs();
        stim_t s[$];
        logic [3:0] e;
        s.push_back(mk(1, 5, 2, 1, 0, 0, 1, 5, 0, 4'b0010));
        s.push_back(mk(1, 5, 2, 1, 0, 0, 0, 5, 0, 4'b1100));
        s.push_back(mk(1, 6, 2, 1, 0, 0, 0, 0, 0, 4'b1100));
        foreach (s[i]) begin
            @(posedge clk); #1; drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL load_use_rs[%0d]: got %b expected %b", i, obs(), e); end
        end
    endtask

    task automatic test_rt_zero();
        stim_t s[$];
        logic [3:0] e;
        s.push_back(mk(1, 3, 7, 0, 0, 0, 1, 7, 0, 4'b1100));
        s.push_back(mk(1, 0, 2, 0, 0, 0, 1, 0, 0, 4'b1100));
        s.push_back(mk(1, 4, 0, 1, 0, 0, 1, 0, 0, 4'b1100));
        s.push_back(mk(1, 3, 7, 1, 0, 0, 1, 7, 0, 4'b0010));
        s.push_back(mk(1, 3, 7, 1, 0, 0, 0, 7, 0, 4'b1100));
        s.push_back(mk(0, 7, 7, 1, 0, 0, 1, 7, 0, 4'b1100));
        foreach (s[i]) begin
            @(posedge clk); #1; drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL rt_zero[%0d]: got %b expected %b", i, obs(), e); end
        end
    endtask

    task automatic test_mdu();
        stim_t s[$];
        logic [3:0] e;
        s.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1100));
        for (int k = 0; k < 4; k++) s.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0011));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1100));
        s.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1100));
        for (int k = 0; k < 4; k++) s.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0011));
        s.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1100));
        for (int k = 0; k < 4; k++) s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1101));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100));
        foreach (s[i]) begin
            @(posedge clk); #1; drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL mdu[%0d]: got %b expected %b", i, obs(), e); end
        end
    endtask

    task automatic test_flush();
        stim_t s[$];
        logic [3:0] e;
        s.push_back(mk(1, 5, 0, 0, 0, 0, 1, 5, 1, 4'b1110));
        s.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 4'b1110));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100));
        s.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1100));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 4'b1111));
        for (int k = 0; k < 3; k++) s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1101));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100));
        foreach (s[i]) begin
            @(posedge clk); #1; drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL flush[%0d]: got %b expected %b", i, obs(), e); end
        end
    endtask

    task automatic test_simultaneous();
        stim_t s[$];
        logic [3:0] e;
        s.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1100));
        s.push_back(mk(1, 9, 0, 0, 0, 1, 1, 9, 0, 4'b0011));
        for (int k = 0; k < 3; k++) s.push_back(mk(1, 9, 0, 0, 0, 1, 0, 9, 0, 4'b0011));
        s.push_back(mk(1, 9, 0, 0, 0, 1, 0, 9, 0, 4'b1100));
        foreach (s[i]) begin
            @(posedge clk); #1; drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL simultaneous[%0d]: got %b expected %b", i, obs(), e); end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        logic [3:0] e;
        for (int k = 1; k <= 3; k++) begin
            s.push_back(mk(1, k + 10, k + 20, 1, 0, 0, 1, k + 20, 0, 4'b0010));
            s.push_back(mk(1, k + 10, k + 20, 1, 0, 0, 0, k + 20, 0, 4'b1100));
        end
        foreach (s[i]) begin
            @(posedge clk); #1; drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL back_to_back[%0d]: got %b expected %b", i, obs(), e); end
        end
    endtask

    task automatic test_reset_mid_busy();
        stim_t s[$];
        logic [3:0] e;
        s.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1100));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1101));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1101));
        foreach (s[i]) begin
            @(posedge clk); #1; drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL rst_busy_pre[%0d]: got %b expected %b", i, obs(), e); end
        end
        // Counter is now 2 with mflo waiting in ID.
        @(posedge clk); #1; drive(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0011));
        #1;
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL rst_busy_cnt2: got %b expected %b", obs(), e); end
        rst_n = 1'b0;
        exp_q.push_back(4'b1100);
        #1;
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL rst_busy_async: got %b expected %b", obs(), e); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1; drive(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1100));
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL rst_busy_after: got %b expected %b", obs(), e); end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        stim_t s[$];
        logic [3:0] e;
        @(negedge clk); rst_n = 1'b0;
        #2; rst_n = 1'b1;
        checks++;
        if (StallCycles !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d expected 0", StallCycles); end
        for (int k = 1; k <= 3; k++) begin
            s.push_back(mk(1, k, 0, 0, 0, 0, 1, k, 0, 4'b0010));
            s.push_back(mk(1, k, 0, 0, 0, 0, 0, k, 0, 4'b1100));
        end
        s.push_back(mk(1, 4, 4, 1, 0, 0, 1, 4, 1, 4'b1110));
        s.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1100));
        for (int k = 0; k < 4; k++) s.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0011));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1100));
        foreach (s[i]) begin
            @(posedge clk); #1; drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL stats_seq[%0d]: got %b expected %b", i, obs(), e); end
        end
        @(posedge clk); #1;
        checks++;
        if (StallCycles !== 16'd7) begin errors++; $display("FAIL stats_count: got %0d expected 7", StallCycles); end
        drive(mk(1, 8, 0, 0, 0, 0, 1, 8, 0, 4'b0010));
        void'(exp_q.pop_front());
        repeat (70000) @(posedge clk);
        @(negedge clk);
        checks++;
        if (StallCycles !== 16'hFFFF) begin errors++; $display("FAIL stats_saturate: got %h expected ffff", StallCycles); end
        @(posedge clk); #1; drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100));
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL stats_idle: got %b expected %b", obs(), e); end
    endtask
`endif

    initial begin
        rst_n       = 1'b0;
        IdValid     = 1'b0;
        IfIdRegRs   = 5'd0;
        IfIdRegRt   = 5'd0;
        IfIdUsesRt  = 1'b0;
        IdIsMdu     = 1'b0;
        IdIsMfhilo  = 1'b0;
        IdExMemRead = 1'b0;
        IdExRegRt   = 5'd0;
        ExFlush     = 1'b0;
        test_reset();
        test_load_use_rs();
        test_rt_zero();
        test_mdu();
        test_flush();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_busy();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
